// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue.
package fetch_queue_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 64;
    localparam logic [ADDR_W-1:0] PC_INC = 64'd4;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } fq_state_t;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } fq_entry_t;

    function automatic logic [ADDR_W-1:0] pc_advance(input logic [ADDR_W-1:0] pc);
        return pc + PC_INC;
    endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Instruction-memory, redirect and decode-side signals of the fetch queue.
interface fetch_queue_if;
    import fetch_queue_pkg::*;

    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;
    logic               redirect;
    logic [ADDR_W-1:0]  redirect_pc;
    logic               id_valid;
    logic [INSTR_W-1:0] id_instr;
    logic [ADDR_W-1:0]  id_pc;
    logic               id_ready;

    modport master (
        output imem_req, imem_addr, id_valid, id_instr, id_pc,
        input  imem_ack, imem_rdata, redirect, redirect_pc, id_ready
    );

    modport slave (
        input  imem_req, imem_addr, id_valid, id_instr, id_pc,
        output imem_ack, imem_rdata, redirect, redirect_pc, id_ready
    );

endinterface

// File: rtl/fetch_queue_instr_fifo2.sv
// Two-entry {instr, pc} FIFO; entry 0 is always the head.
module instr_fifo2
    import fetch_queue_pkg::*;
(
    input  logic      clk,
    input  logic      reset_n,
    input  logic      push,
    input  fq_entry_t push_data,
    input  logic      pop,
    input  logic      flush,
    output fq_entry_t head,
    output logic [1:0] count
);

    fq_entry_t  entry0_r;
    fq_entry_t  entry1_r;
    logic [1:0] count_r;
    logic       push_ok_s;
    logic       pop_ok_s;

    // Qualify push/pop against occupancy so illegal requests are ignored.
    always_comb begin
        push_ok_s = push && (count_r != 2'd2);
        pop_ok_s  = pop && (count_r != 2'd0);
    end

    // Storage and occupancy update; flush only drops the count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            entry0_r <= '0;
            entry1_r <= '0;
            count_r  <= 2'd0;
        end else if (flush) begin
            count_r <= 2'd0;
        end else begin
            case ({push_ok_s, pop_ok_s})
                2'b10: begin
                    if (count_r == 2'd0) begin
                        entry0_r <= push_data;
                    end else begin
                        entry1_r <= push_data;
                    end
                    count_r <= count_r + 2'd1;
                end
                2'b01: begin
                    entry0_r <= entry1_r;
                    count_r  <= count_r - 2'd1;
                end
                2'b11: begin
                    if (count_r == 2'd1) begin
                        entry0_r <= push_data;
                    end else begin
                        entry0_r <= entry1_r;
                        entry1_r <= push_data;
                    end
                end
                default: begin
                    count_r <= count_r;
                end
            endcase
        end
    end

    assign head  = entry0_r;
    assign count = count_r;

endmodule

// File: rtl/fetch_queue.sv
// Fetch sequencer: issues one instruction-memory request at a time and
// queues returned words for decode, discarding data made stale by redirects.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          DEPTH    = 2
) (
    input  logic          clk,
    input  logic          reset_n,
    fetch_queue_if.master bus
);

    localparam logic [1:0] FULL_CNT = 2'(DEPTH);

    fq_state_t         state_r;
    logic [ADDR_W-1:0] fetch_pc_r;
    logic [ADDR_W-1:0] pending_pc_r;
    logic [1:0]        count_s;
    fq_entry_t         head_s;
    fq_entry_t         push_data_s;
    logic              imem_req_s;
    logic              ack_s;
    logic              push_s;
    logic              pop_s;
    logic              valid_s;

    // Request level and handshake qualification; request is forced low in reset.
    always_comb begin
        if (!reset_n) begin
            imem_req_s = 1'b0;
        end else if (state_r == DRAIN) begin
            imem_req_s = 1'b1;
        end else begin
            imem_req_s = (count_s < FULL_CNT);
        end
        ack_s       = bus.imem_ack && imem_req_s;
        valid_s     = (count_s != 2'd0);
        push_s      = (state_r == RUN) && ack_s && !bus.redirect;
        pop_s       = valid_s && bus.id_ready && !bus.redirect;
        push_data_s = '{instr: bus.imem_rdata, pc: fetch_pc_r};
    end

    instr_fifo2 u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push_s),
        .push_data (push_data_s),
        .pop       (pop_s),
        .flush     (bus.redirect),
        .head      (head_s),
        .count     (count_s)
    );

    // FSM and PC tracking. A redirect with a request in flight must wait for
    // that request's ack (DRAIN) before the new address can be presented.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= RUN;
            fetch_pc_r   <= RESET_PC;
            pending_pc_r <= 64'h0;
        end else begin
            case (state_r)
                RUN: begin
                    if (bus.redirect) begin
                        pending_pc_r <= bus.redirect_pc;
                        if (imem_req_s && !ack_s) begin
                            state_r <= DRAIN;
                        end else begin
                            fetch_pc_r <= bus.redirect_pc;
                        end
                    end else if (ack_s) begin
                        fetch_pc_r <= pc_advance(fetch_pc_r);
                    end
                end
                DRAIN: begin
                    if (ack_s) begin
                        state_r    <= RUN;
                        fetch_pc_r <= bus.redirect ? bus.redirect_pc : pending_pc_r;
                        if (bus.redirect) begin
                            pending_pc_r <= bus.redirect_pc;
                        end
                    end else if (bus.redirect) begin
                        pending_pc_r <= bus.redirect_pc;
                    end
                end
                default: begin
                    state_r <= RUN;
                end
            endcase
        end
    end

    assign bus.imem_req  = imem_req_s;
    assign bus.imem_addr = fetch_pc_r;
    assign bus.id_valid  = valid_s;
    assign bus.id_instr  = head_s.instr;
    assign bus.id_pc     = head_s.pc;

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized scoreboard bench for fetch_queue against a fetch-stream model.
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    fetch_queue_if bus ();

    fetch_queue #(.RESET_PC(64'h0), .DEPTH(2)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int tests = 0;
    int fails = 0;

    exp_t sb[$];
    exp_t pend[$];
    logic [63:0] next_pc_m;
    logic [63:0] cur_addr_m;
    bit stale_m;
    bit cont_m;
    int ack_pct, rdy_pct, rdr_pct;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        pend.delete();
        next_pc_m  = 64'h0;
        cur_addr_m = 64'h0;
        stale_m    = 1'b0;
        cont_m     = 1'b0;
    endtask

    function automatic logic [63:0] pick_pc();
        logic [63:0] v;
        case ($urandom_range(3))
            0:       v = 64'hFFFF_FFFF_FFFF_FFF8;
            1:       v = {$urandom, $urandom} & ~64'h3;
            default: v = 64'(($urandom_range(255)) * 4);
        endcase
        return v;
    endfunction

    // Memory / branch side: drives inputs and tracks where fetching should be.
    task automatic run_stim(input int n);
        logic req, ack, rdr, acc;
        logic [63:0] rpc;
        logic [31:0] data;
        for (int i = 0; i < n; i++) begin
            if (i != 0) @(negedge clk);
            #1;
            req = bus.imem_req;
            chk("imem_req", 64'(req), 64'(stale_m || (sb.size() < 2)));
            if (req) begin
                if (!cont_m) begin
                    chk("imem_addr_new", bus.imem_addr, next_pc_m);
                    cur_addr_m = next_pc_m;
                end else begin
                    chk("imem_addr_hold", bus.imem_addr, cur_addr_m);
                end
            end
            ack  = req ? ($urandom_range(99) < ack_pct) : ($urandom_range(99) < 5);
            rdr  = ($urandom_range(99) < rdr_pct);
            rpc  = pick_pc();
            data = $urandom;
            bus.imem_ack    = ack;
            bus.imem_rdata  = data;
            bus.redirect    = rdr;
            bus.redirect_pc = rpc;
            bus.id_ready    = ($urandom_range(99) < rdy_pct);
            acc = ack && req;
            if (rdr) begin
                next_pc_m = rpc;
                stale_m   = req && !acc;
            end else if (acc) begin
                if (!stale_m) begin
                    pend.push_back('{pc: cur_addr_m, instr: data});
                    next_pc_m = cur_addr_m + 64'd4;
                end
                stale_m = 1'b0;
            end
            cont_m = req && !acc;
        end
    endtask

    // Decode side monitor: checks the head against the scoreboard, then applies
    // this cycle's pop/flush and the pushes issued by the stimulus.
    task automatic run_mon(input int n);
        for (int i = 0; i < n; i++) begin
            if (i != 0) @(negedge clk);
            #4;
            chk("id_valid", 64'(bus.id_valid), 64'(sb.size() > 0));
            if (bus.id_valid && sb.size() > 0) begin
                chk("id_pc", bus.id_pc, sb[0].pc);
                chk("id_instr", 64'(bus.id_instr), 64'(sb[0].instr));
            end
            if (bus.redirect) begin
                sb.delete();
            end else if (bus.id_valid && bus.id_ready && sb.size() > 0) begin
                void'(sb.pop_front());
            end
            while (pend.size() > 0) sb.push_back(pend.pop_front());
        end
    endtask

    task automatic segment(input int n, input int a, input int r, input int d);
        ack_pct = a;
        rdy_pct = r;
        rdr_pct = d;
        fork
            run_stim(n);
            run_mon(n);
        join
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_imem_req"}, 64'(bus.imem_req), 64'd0);
        chk({tag, "_id_valid"}, 64'(bus.id_valid), 64'd0);
        chk({tag, "_id_instr"}, 64'(bus.id_instr), 64'd0);
        chk({tag, "_id_pc"}, bus.id_pc, 64'd0);
    endtask

    initial begin
        reset_n         = 1'b0;
        bus.imem_ack    = 1'b0;
        bus.imem_rdata  = 32'h0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 64'h0;
        bus.id_ready    = 1'b0;
        model_reset();
        #2;
        check_reset_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        segment(20, 100, 100, 0);
        @(negedge clk);
        segment(10, 100, 0, 0);
        @(negedge clk);
        segment(10, 100, 100, 0);
        @(negedge clk);
        segment(1500, 50, 70, 15);
        @(negedge clk);
        segment(500, 70, 50, 30);
        bus.imem_ack = 1'b0;
        bus.redirect = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        model_reset();
        bus.imem_ack = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        segment(500, 60, 60, 20);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter RESET_PC, default 64'h0, first fetch address after reset.
REQ-002 Parameter DEPTH, default 2, instruction queue entries (fixed 2 in this revision).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 imem_req  output  1  instruction-memory request, level.
REQ-006 imem_addr  output  64  fetch address, stable while imem_req is high.
REQ-007 imem_ack  input  1  one-cycle pulse; imem_rdata is valid in that cycle.
REQ-008 imem_rdata  input  32  fetched instruction word.
REQ-009 redirect  input  1  one-cycle pulse from a taken branch; flushes the fetch stream.
REQ-010 redirect_pc  input  64  new fetch address, sampled when redirect=1.
REQ-011 id_valid  output  1  queue head is valid toward decode and the delay-slot logic.
REQ-012 id_instr  output  32  instruction at the queue head.
REQ-013 id_pc  output  64  address of id_instr.
REQ-014 id_ready  input  1  decode accepts the head; a pop occurs when id_valid && id_ready.

Function
REQ-015 The FSM SHALL have two states: RUN and DRAIN.
REQ-016 The queue SHALL hold up to 2 {instr, pc} entries, FIFO order, with a 2-bit count (0..2).
REQ-017 imem_req SHALL equal (state==RUN && count<2) || state==DRAIN.
REQ-018 Once imem_req is asserted, it SHALL stay high with imem_addr unchanged until imem_ack; at most one request is outstanding.
REQ-019 In RUN, imem_ack without redirect SHALL push {imem_rdata, fetch_pc} and advance fetch_pc by 4 (mod 2^64, wraps).
REQ-020 A pop SHALL remove the head in the same cycle; push and pop together SHALL leave count unchanged.
REQ-021 A push with count==2 is impossible under REQ-017; an imem_ack with no request outstanding SHALL be ignored.
REQ-022 Latency: imem_ack in cycle N with an empty queue SHALL give id_valid=1 in cycle N+1.
REQ-023 id_valid SHALL be 1 iff count>0; id_instr and id_pc SHALL show the head entry.
REQ-024 A redirect SHALL clear the queue (count<=0, any pop that cycle is ignored) and store redirect_pc in pending_pc.
REQ-025 Redirect in RUN with a request outstanding and no ack: go to DRAIN.
REQ-026 Redirect in RUN with no request outstanding, or with ack in the same cycle: discard that ack's data, set fetch_pc<=redirect_pc, stay RUN.
REQ-027 In DRAIN, imem_ack SHALL be discarded, fetch_pc<=pending_pc, and the FSM SHALL go to RUN.
REQ-028 In DRAIN, a further redirect SHALL overwrite pending_pc; if it coincides with ack, redirect_pc is used directly.
REQ-029 id_valid SHALL stay 0 throughout DRAIN.

Reset
REQ-030 While reset_n=0: state=RUN, count=0, fetch_pc=RESET_PC, pending_pc=0, outstanding flag=0, imem_req=0 (combinationally forced), id_valid=0, id_instr=0, id_pc=0.
REQ-031 Reset during an outstanding request SHALL abandon it; the first ack after release with no new request SHALL be ignored (REQ-021).
REQ-032 The first request SHALL be issued in the first cycle after reset_n deasserts, with imem_addr=RESET_PC.

Structure
REQ-033 A shared package SHALL hold the state enum (RUN, DRAIN), the instruction width (32), the address width (64), and the PC increment (4).
REQ-034 The 2-entry queue SHALL be one sub-module, instr_fifo2, with push/pop/flush/count ports; the FSM and PC logic stay in fetch_queue.

Verification
REQ-035 Reset release, ack every cycle, id_ready=1: id_pc sequence 0,4,8,12; id_instr matches rdata in order; one instruction per cycle after the first.
REQ-036 id_ready=0, acks supplied: after 2 pushes count=2 and imem_req=0; on id_ready=1, pops in order and imem_req reasserts.
REQ-037 Redirect to 0x100 while a request to 0x8 waits for ack: ack data dropped, next imem_addr=0x100, no id_valid before the 0x100 word arrives.
REQ-038 Redirect to 0x200 together with imem_ack and a pending pop: queue empty next cycle, data dropped, imem_addr=0x200, state RUN.
REQ-039 Two redirects (0x300, then 0x400) during DRAIN before ack: the fetch resumes at 0x400.
REQ-040 reset_n pulsed low mid-request with count=1: all outputs go to reset values immediately; after release imem_addr=RESET_PC.
